// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the BCD counter / seven-segment display block.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segment patterns, bit order dp g f e d c b a (dp always off).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Non-BCD codes render as a dark digit rather than garbage.
  function automatic logic [7:0] bcd_to_seg(input bcd_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_bcd_counter_bcd_digit.sv
// One BCD digit of the ripple-enabled counter chain.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
  input  logic step_i,
  input  logic up_i,
  input  logic clr_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic cin_i,
  output logic cout_o,
  output bcd_t digit_o
);

  bcd_t digit_q;
  bcd_t digit_d;
  logic terminal;

  assign terminal = up_i ? (digit_q == 4'd9) : (digit_q == 4'd0);
  // Next digit is allowed to move only when this one and all lower ones are at terminal.
  assign cout_o   = cin_i & terminal;
  assign digit_o  = digit_q;

  // Next-state: clear beats load beats count step.
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = (load_val_i > 4'd9) ? 4'd0 : load_val_i;
    end else if (step_i && cin_i) begin
      if (up_i) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      else      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) digit_q <= '0;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/seg7_bcd_counter.sv
// Multi-digit BCD up/down counter with multiplexed 8-anode seven-segment driver.
module seg7_bcd_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000,
  parameter int LEAD_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  carry_o,
  output logic [7:0]            disp_seg_o,
  output logic [7:0]            disp_an_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic            carry_q, carry_d;
  logic            tick;
  logic [DIGITS:0] chain;

  logic [SW-1:0]   scan_cnt_q;
  logic [2:0]      scan_idx_q;
  logic [7:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic [DIGITS-1:0] blank_v;
  bcd_t            sel_digit;
  logic            sel_blank;

  assign tick     = en_i && (presc_q == PRESC_LAST);
  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_i      (RST),
      .step_i     (tick),
      .up_i       (up_i),
      .clr_i      (clr_i),
      .load_i     (load_i),
      .load_val_i (load_val_i[4*k +: 4]),
      .cin_i      (chain[k]),
      .cout_o     (chain[k+1]),
      .digit_o    (count_o[4*k +: 4])
    );
  end

  // Prescaler next-state and wrap-pulse decode; clear/load restart the tick period.
  always_comb begin
    presc_d = presc_q;
    carry_d = 1'b0;
    if (clr_i || load_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      carry_d = tick && chain[DIGITS];
    end
  end

  // Prescaler and carry pulse registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      presc_q <= '0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

  // Leading-zero blanking: walk from the top digit down while everything seen is zero.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    blank_v     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      higher_zero = higher_zero && (count_o[4*(DIGITS-1-i) +: 4] == 4'd0);
      blank_v[DIGITS-1-i] = (LEAD_BLANK != 0) && (i != DIGITS - 1) && higher_zero;
    end
  end

  // Select the digit under the current scan index and build anode/segment patterns.
  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == 3'(i)) begin
        sel_digit = count_o[4*i +: 4];
        sel_blank = blank_v[i];
      end
    end
    an_d             = ANODE_OFF;
    an_d[scan_idx_q] = 1'b0;
    seg_d            = sel_blank ? SEG_BLANK : bcd_to_seg(sel_digit);
  end

  // Scan timing and registered display outputs; anode and segments update together.
  always_ff @(posedge clk) begin
    if (RST) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      an_q       <= ANODE_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IDX_LAST) ? 3'd0 : scan_idx_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
    end
  end

  assign disp_an_o  = an_q;
  assign disp_seg_o = seg_q;

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Scoreboard bench: stimulus schedules expectations by cycle, a negedge monitor checks them.
module tb_seg7_bcd_counter;

  logic        clk;
  logic        RST;
  logic        en_i, clr_i, up_i, load_i;
  logic [15:0] load_val_i;
  logic [15:0] count_o;
  logic        carry_o;
  logic [7:0]  disp_seg_o, disp_an_o;

  seg7_bcd_counter #(
    .DIGITS     (4),
    .TICK_DIV   (4),
    .SCAN_DIV   (2),
    .LEAD_BLANK (1)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .up_i       (up_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .count_o    (count_o),
    .carry_o    (carry_o),
    .disp_seg_o (disp_seg_o),
    .disp_an_o  (disp_an_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_COUNT, K_CARRY, K_AN, K_SEG} kind_e;
  typedef struct {
    int unsigned cyc;
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        keep_q[$];
  int unsigned cyc = 0;
  int unsigned scan_base = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle against the DUT outputs.
  always @(negedge clk) begin
    logic [15:0] act;
    keep_q = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_COUNT: act = count_o;
          K_CARRY: act = {15'd0, carry_o};
          K_AN:    act = {8'd0, disp_an_o};
          default: act = {8'd0, disp_seg_o};
        endcase
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d never checked", sb[i].name, sb[i].cyc);
      end else begin
        keep_q.push_back(sb[i]);
      end
    end
    sb = keep_q;
  end

  task automatic expect_at(input int unsigned off, input kind_e k, input logic [15:0] v,
                           input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_i     = 1'b1;
    load_val_i = v;
    step(1);
    load_i     = 1'b0;
  endtask

  // Anode k is lit for two cycles in turn, starting with digit 0 on the first edge after reset.
  task automatic push_scan(input int unsigned from_off, input int unsigned n,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input string nm);
    int unsigned idx;
    logic [7:0]  an;
    logic [7:0]  sg;
    for (int unsigned o = from_off; o < from_off + n; o++) begin
      idx = ((cyc + o - scan_base) / 2) % 4;
      an  = 8'hFF;
      an[idx] = 1'b0;
      case (idx)
        0:       sg = s0;
        1:       sg = s1;
        2:       sg = s2;
        default: sg = s3;
      endcase
      expect_at(o, K_AN,  {8'd0, an}, {nm, "_an"});
      expect_at(o, K_SEG, {8'd0, sg}, {nm, "_seg"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; en_i = 1'b0; clr_i = 1'b0; up_i = 1'b1; load_i = 1'b0; load_val_i = '0;

    // Reset state
    step(1);
    expect_at(0, K_COUNT, 16'h0000, "rst_count");
    expect_at(0, K_CARRY, 16'h0000, "rst_carry");
    expect_at(0, K_AN,    16'h00FF, "rst_an");
    expect_at(0, K_SEG,   16'h00FF, "rst_seg");
    expect_at(2, K_AN,    16'h00FF, "rst_an_hold");
    step(2);
    RST = 1'b0;
    scan_base = cyc + 1;
    expect_at(1, K_COUNT, 16'h0000, "rel_count");
    push_scan(1, 2, 8'hC0, 8'hFF, 8'hFF, 8'hFF, "rel");
    step(2);

    // Up wrap 9999 -> 0000 with one-cycle carry
    en_i = 1'b1; up_i = 1'b1;
    expect_at(1, K_COUNT, 16'h9999, "ld9999");
    expect_at(4, K_COUNT, 16'h9999, "pre_tick_hold");
    expect_at(4, K_CARRY, 16'h0000, "pre_tick_carry");
    expect_at(5, K_COUNT, 16'h0000, "up_wrap");
    expect_at(5, K_CARRY, 16'h0001, "up_carry");
    expect_at(6, K_CARRY, 16'h0000, "up_carry_end");
    expect_at(6, K_COUNT, 16'h0000, "up_wrap_hold");
    do_load(16'h9999);
    step(5);

    // Down: borrow across digits, then full wrap 0000 -> 9999
    up_i = 1'b0;
    expect_at(1, K_COUNT, 16'h1000, "ld1000");
    expect_at(5, K_COUNT, 16'h0999, "down_borrow");
    expect_at(5, K_CARRY, 16'h0000, "down_nocarry");
    do_load(16'h1000);
    step(4);
    expect_at(1, K_COUNT, 16'h0000, "ld0000");
    expect_at(5, K_COUNT, 16'h9999, "down_wrap");
    expect_at(5, K_CARRY, 16'h0001, "down_carry");
    expect_at(6, K_CARRY, 16'h0000, "down_carry_end");
    do_load(16'h0000);
    step(5);

    // Up ripple 0199 -> 0200, then hold with en low while scanning continues
    up_i = 1'b1;
    expect_at(1, K_COUNT, 16'h0199, "ld0199");
    expect_at(5, K_COUNT, 16'h0200, "up_ripple");
    do_load(16'h0199);
    step(4);
    en_i = 1'b0;
    expect_at(1,  K_COUNT, 16'h0200, "hold_1");
    expect_at(10, K_COUNT, 16'h0200, "hold_10");
    expect_at(20, K_COUNT, 16'h0200, "hold_20");
    expect_at(20, K_CARRY, 16'h0000, "hold_carry");
    push_scan(1, 8, 8'hC0, 8'hC0, 8'hA4, 8'hFF, "hold_scan");
    step(20);

    // Clear beats load; load replaces non-BCD digits with 0
    clr_i = 1'b1; load_i = 1'b1; load_val_i = 16'h5555;
    expect_at(1, K_COUNT, 16'h0000, "clr_over_load");
    step(1);
    clr_i = 1'b0; load_i = 1'b0;
    expect_at(1, K_COUNT, 16'h1204, "ld_sanitize");
    do_load(16'h12A4);
    push_scan(1, 8, 8'h99, 8'hC0, 8'hA4, 8'hF9, "scan1204");
    step(9);
    clr_i = 1'b1;
    expect_at(1, K_COUNT, 16'h0000, "clr_only");
    expect_at(1, K_CARRY, 16'h0000, "clr_carry");
    step(1);
    clr_i = 1'b0;

    // Display of 0042 with leading blanking
    expect_at(1, K_COUNT, 16'h0042, "ld0042");
    do_load(16'h0042);
    push_scan(1, 8, 8'hA4, 8'h99, 8'hFF, 8'hFF, "scan0042");
    step(9);

    step(2);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cyc %0d left unchecked", sb[i].name, sb[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
